// File: rtl/demux8_2_buf.sv
// Routes each input word to one of two buffered output channels (A or B).
// Each channel has its own small FIFO and a free-running delivered-word counter.

module demux8_2_buf_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] head
);
    localparam int PW = (DEPTH > 2) ? 2 : 1;
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    occ;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign full  = (occ == CW'(DEPTH));
    assign valid = (occ != '0);
    assign head  = mem[rd_ptr];
endmodule

module demux8_2_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic [7:0]       a_count,
    output logic [7:0]       b_count
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // in_ready looks only at the selected FIFO's fill level, never at a_ready/b_ready.
    logic a_full;
    logic b_full;
    logic push_a;
    logic push_b;
    logic pop_a;
    logic pop_b;

    assign in_ready = in_sel ? !a_full : !b_full;
    assign push_a   = in_valid && in_ready && in_sel;
    assign push_b   = in_valid && in_ready && !in_sel;
    assign pop_a    = a_valid && a_ready;
    assign pop_b    = b_valid && b_ready;

    demux8_2_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_a),
        .wdata (in_data),
        .pop   (pop_a),
        .full  (a_full),
        .valid (a_valid),
        .head  (a_data)
    );

    demux8_2_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_b),
        .wdata (in_data),
        .pop   (pop_b),
        .full  (b_full),
        .valid (b_valid),
        .head  (b_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (pop_a) a_count <= a_count + 8'd1;
            if (pop_b) b_count <= b_count + 8'd1;
        end
    end
endmodule
